// File: rtl/dmem_pkg.sv
// Shared definitions for the word-copy DMA: FSM state encoding and address stride.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WSTRIDE = 4;

endpackage

// File: rtl/dmem.sv
// Word-organised data memory: combinational read, write on rising clk edge.
// Byte address a; bits [DWIDTH-1:2] select the word, low bits ignored.
module dmem #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] wd,
  output logic [DWIDTH-1:0] rd
);

  logic [DWIDTH-1:0] ram [2**(DWIDTH-2)];
  logic              unused_lsb;

  assign unused_lsb = ^a[1:0];
  assign rd = ram[a[DWIDTH-1:2]];

  always_ff @(posedge clk) begin
    if (we) ram[a[DWIDTH-1:2]] <= wd;
  end

endmodule

// File: rtl/dmem_dma.sv
// Memory-to-memory word copier: 2 cycles per word (read, then write), done pulses 1 cycle after the last write.
// Start is sampled only in IDLE; requests arriving while busy are dropped, not queued.
module dmem_dma
  import dmem_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] src,
  input  logic [DWIDTH-1:0] dst,
  input  logic [LWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_a,
  output logic [DWIDTH-1:0] mem_wd,
  input  logic [DWIDTH-1:0] mem_rd
);

  localparam logic [DWIDTH-1:0] STRIDE = DWIDTH'(WSTRIDE);

  state_t            state;
  logic [DWIDTH-1:0] sptr;
  logic [DWIDTH-1:0] dptr;
  logic [LWIDTH-1:0] cnt;
  logic [DWIDTH-1:0] data;

  // Write data is only presented while the write strobe is up.
  assign mem_wd = (state == WRITE) ? data : '0;

  // Outputs are computed from the next state so they are valid for the whole cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sptr   <= '0;
      dptr   <= '0;
      cnt    <= '0;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mem_we <= 1'b0;
      mem_a  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sptr <= src;
            dptr <= dst;
            cnt  <= len;
            if (len != '0) begin
              state <= READ;
              busy  <= 1'b1;
              mem_a <= src;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          data   <= mem_rd;
          state  <= WRITE;
          mem_we <= 1'b1;
          mem_a  <= dptr;
        end
        WRITE: begin
          sptr   <= sptr + STRIDE;
          dptr   <= dptr + STRIDE;
          cnt    <= cnt - LWIDTH'(1);
          mem_we <= 1'b0;
          if (cnt == LWIDTH'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            mem_a <= '0;
          end else begin
            state <= READ;
            mem_a <= sptr + STRIDE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_we <= 1'b0;
          mem_a  <= '0;
        end
      endcase
    end
  end

endmodule
